// File: rtl/pmem_scheduler_pkg.sv
// Shared types for the I/D memory-port scheduler and its victim buffer.
package pmem_scheduler_pkg;
  localparam int PMEM_ADDR_BITS   = 32;
  localparam int PMEM_LINE_BITS   = 256;
  localparam int PMEM_OFFSET_BITS = 5;

  typedef logic [PMEM_LINE_BITS-1:0] cacheline_t;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_IREAD,
    SCHED_DREAD,
    SCHED_DRAIN
  } sched_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;
endpackage

// File: rtl/pmem_scheduler_wb_buffer.sv
// One-entry victim buffer holding a single D-cache writeback line.
module pmem_scheduler_wb_buffer
  import pmem_scheduler_pkg::*;
#(
  parameter int ADDR_BITS   = PMEM_ADDR_BITS,
  parameter int LINE_BITS   = PMEM_LINE_BITS,
  parameter int OFFSET_BITS = PMEM_OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [ADDR_BITS-1:0] d_addr,
  output logic                 valid,
  output logic [ADDR_BITS-1:0] addr,
  output logic [LINE_BITS-1:0] line,
  output logic                 match_i,
  output logic                 match_d
);
  logic                 valid_q, valid_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    line_d  = line_q;
    if (clear) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = load_addr;
      line_d  = load_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Line match ignores the byte offset within the cacheline.
  assign match_i = valid_q && (i_addr[ADDR_BITS-1:OFFSET_BITS] == addr_q[ADDR_BITS-1:OFFSET_BITS]);
  assign match_d = valid_q && (d_addr[ADDR_BITS-1:OFFSET_BITS] == addr_q[ADDR_BITS-1:OFFSET_BITS]);
  assign valid   = valid_q;
  assign addr    = addr_q;
  assign line    = line_q;
endmodule

// File: rtl/pmem_scheduler.sv
// Shares one cacheline adaptor between I-cache and D-cache with a one-line victim buffer.
// Build option: PMEM_SCHED_FWD_EN lets reads that hit the buffered line be answered from it.
module pmem_scheduler
  import pmem_scheduler_pkg::*;
#(
  parameter int ADDR_BITS   = PMEM_ADDR_BITS,
  parameter int LINE_BITS   = PMEM_LINE_BITS,
  parameter int OFFSET_BITS = PMEM_OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] instr_mem_address,
  input  logic                 instr_mem_read,
  output logic [LINE_BITS-1:0] instr_mem_burst,
  output logic                 instr_mem_resp,
  input  logic [ADDR_BITS-1:0] data_mem_address,
  input  logic                 data_mem_read,
  input  logic                 data_mem_write,
  input  logic [LINE_BITS-1:0] data_cache_burst,
  output logic [LINE_BITS-1:0] data_mem_burst,
  output logic                 data_mem_resp,
  output logic [ADDR_BITS-1:0] pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wburst,
  input  logic [LINE_BITS-1:0] pmem_rburst,
  input  logic                 pmem_resp
);
  sched_state_t         state_q, state_d;
  grant_t               last_grant_q, last_grant_d;
  logic                 pmem_read_q, pmem_read_d;
  logic                 pmem_write_q, pmem_write_d;
  logic [ADDR_BITS-1:0] pmem_addr_q, pmem_addr_d;

  logic                 wb_load, wb_clear, wb_valid, match_i, match_d;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [LINE_BITS-1:0] wb_line;

  pmem_scheduler_wb_buffer #(
    .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .OFFSET_BITS(OFFSET_BITS)
  ) u_wb_buffer (
    .clk(clk), .rst(rst), .load(wb_load), .clear(wb_clear),
    .load_addr(data_mem_address), .load_line(data_cache_burst),
    .i_addr(instr_mem_address), .d_addr(data_mem_address),
    .valid(wb_valid), .addr(wb_addr), .line(wb_line),
    .match_i(match_i), .match_d(match_d)
  );

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    pmem_read_d     = pmem_read_q;
    pmem_write_d    = pmem_write_q;
    pmem_addr_d     = pmem_addr_q;
    wb_load         = 1'b0;
    wb_clear        = 1'b0;
    instr_mem_resp  = 1'b0;
    instr_mem_burst = '0;
    data_mem_resp   = 1'b0;
    data_mem_burst  = '0;
    unique case (state_q)
      SCHED_IDLE: begin
        if (data_mem_write && !wb_valid) begin
          wb_load       = 1'b1;
          data_mem_resp = 1'b1;
        end else if ((data_mem_read && match_d) || (instr_mem_read && match_i)) begin
`ifdef PMEM_SCHED_FWD_EN
          if (data_mem_read && match_d) begin
            data_mem_resp  = 1'b1;
            data_mem_burst = wb_line;
          end else begin
            instr_mem_resp  = 1'b1;
            instr_mem_burst = wb_line;
          end
`else
          state_d      = SCHED_DRAIN;
          pmem_write_d = 1'b1;
          pmem_addr_d  = wb_addr;
`endif
        end else if (instr_mem_read && (!data_mem_read || last_grant_q == GRANT_D)) begin
          state_d      = SCHED_IREAD;
          pmem_read_d  = 1'b1;
          pmem_addr_d  = instr_mem_address;
          last_grant_d = GRANT_I;
        end else if (data_mem_read) begin
          state_d      = SCHED_DREAD;
          pmem_read_d  = 1'b1;
          pmem_addr_d  = data_mem_address;
          last_grant_d = GRANT_D;
        end else if (wb_valid) begin
          state_d      = SCHED_DRAIN;
          pmem_write_d = 1'b1;
          pmem_addr_d  = wb_addr;
        end
      end
      SCHED_IREAD: if (pmem_resp) begin
        instr_mem_resp  = 1'b1;
        instr_mem_burst = pmem_rburst;
        state_d         = SCHED_IDLE;
        pmem_read_d     = 1'b0;
        pmem_addr_d     = '0;
      end
      SCHED_DREAD: if (pmem_resp) begin
        data_mem_resp  = 1'b1;
        data_mem_burst = pmem_rburst;
        state_d        = SCHED_IDLE;
        pmem_read_d    = 1'b0;
        pmem_addr_d    = '0;
      end
      SCHED_DRAIN: if (pmem_resp) begin
        wb_clear     = 1'b1;
        state_d      = SCHED_IDLE;
        pmem_write_d = 1'b0;
        pmem_addr_d  = '0;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCHED_IDLE;
      last_grant_q <= GRANT_D;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_addr_q  <= pmem_addr_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_addr_q;
  assign pmem_wburst  = wb_line;
endmodule
